// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared widths, register-index constants and datapath typedefs
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Architectural $zero; reads as 0 and ignores writes.
  localparam int ZERO_REG = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : mips_reg_file
// Brief    : 32-entry GPR file, two combinational read ports with write-through
//            bypass, one clocked write port, asynchronous active-low clear
// Revision : 1.0 - initial release
// ============================================================================
module mips_reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int                c_NREGS    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [c_NREGS];
  logic              w_wr_hit;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  // Qualified write: also drives the bypass, so reset and $zero block both.
  assign w_wr_hit = rst_n && we && (waddr != c_ZERO_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rport
      assign w_rdata[p] = (!rst_n || (w_raddr[p] == c_ZERO_IDX)) ? '0 :
                          (w_wr_hit && (waddr == w_raddr[p]))    ? wdata :
                                                                   r_regs[w_raddr[p]];
    end
  endgenerate

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];

endmodule : mips_reg_file
`default_nettype wire

// File: tb/tb_mips_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_reg_file
// Brief    : Scoreboard bench for mips_reg_file against a reference array model
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_reg_file;
  import mips_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     we;
  reg_idx_t waddr, raddr1, raddr2;
  word_t    wdata, rdata1, rdata2;

  word_t model [32];
  int    total = 0;
  int    bad   = 0;

  typedef struct {
    string tag;
    bit    port2;
    word_t exp;
  } sb_item_t;

  sb_item_t sb_q [$];

  always #5 clk = ~clk;

  mips_reg_file dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  task automatic chk(input string tag, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic word_t exp_rd(input reg_idx_t a);
    if (!rst_n || a == 5'd0) return '0;
    if (we && waddr != 5'd0 && waddr == a) return wdata;
    return model[a];
  endfunction

  // Set read addresses, push expectations, let combinational paths settle, compare.
  task automatic read_chk(input string tag, input reg_idx_t a1, input reg_idx_t a2);
    sb_item_t it;
    raddr1 = a1;
    raddr2 = a2;
    it.tag = {tag, "/rd1"}; it.port2 = 1'b0; it.exp = exp_rd(a1); sb_q.push_back(it);
    it.tag = {tag, "/rd2"}; it.port2 = 1'b1; it.exp = exp_rd(a2); sb_q.push_back(it);
    #1;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      chk(it.tag, it.port2 ? rdata2 : rdata1, it.exp);
    end
  endtask

  // Advance one rising edge, committing to the model what the DUT should commit.
  task automatic tick();
    @(posedge clk);
    if (rst_n && we && waddr != 5'd0) model[waddr] = wdata;
    #1;
  endtask

  task automatic drive_wr(input bit en, input reg_idx_t a, input word_t d);
    @(negedge clk);
    we = en; waddr = a; wdata = d;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    foreach (model[i]) model[i] = '0;
  endtask

  initial begin
    foreach (model[i]) model[i] = '0;
    we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    assert_reset();
    #3;
    read_chk("reset_init", 5'd7, 5'd31);
    @(negedge clk);
    rst_n = 1'b1;

    // Load r1..r31 with nonzero patterns, then read every index on both ports.
    for (int i = 1; i < 32; i++) begin
      drive_wr(1'b1, reg_idx_t'(i), word_t'(i) * 32'h0101_0101 ^ 32'h00A5_0000);
      tick();
    end
    drive_wr(1'b0, '0, '0);
    for (int i = 0; i < 32; i++) read_chk("load", reg_idx_t'(i), reg_idx_t'(31 - i));

    // Asynchronous reset between edges: outputs drop at once, stay 0 after release.
    #2;
    assert_reset();
    #1;
    for (int i = 0; i < 32; i += 5) read_chk("reset_async", reg_idx_t'(i), reg_idx_t'(i + 1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) read_chk("reset_after", reg_idx_t'(i), reg_idx_t'(31 - i));

    // Basic write/read on consecutive edges.
    drive_wr(1'b1, 5'd8, 32'd5); tick();
    drive_wr(1'b1, 5'd9, 32'd9); tick();
    drive_wr(1'b0, '0, '0);
    read_chk("basic", 5'd8, 5'd9);
    chk("basic_r8_const", rdata1, 32'd5);
    chk("basic_r9_const", rdata2, 32'd9);

    // $zero ignores writes, before and after the edge.
    drive_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    read_chk("zero_pre", 5'd0, 5'd0);
    tick();
    read_chk("zero_post", 5'd0, 5'd8);

    // Bypass: r4 holds 7, overwrite with 0 and with a visible nonzero value.
    drive_wr(1'b1, 5'd4, 32'd7); tick();
    drive_wr(1'b1, 5'd4, 32'd0);
    read_chk("bypass0_pre", 5'd9, 5'd4);
    chk("bypass0_pre_const", rdata2, 32'd0);
    tick();
    drive_wr(1'b0, '0, '0);
    read_chk("bypass0_post", 5'd4, 5'd4);
    drive_wr(1'b1, 5'd4, 32'hDEAD_BEEF);
    read_chk("bypass_val_pre", 5'd4, 5'd5);
    chk("bypass_val_const", rdata1, 32'hDEAD_BEEF);
    tick();
    drive_wr(1'b0, '0, '0);
    read_chk("bypass_val_post", 5'd4, 5'd4);

    // Dual read of the same index.
    drive_wr(1'b1, 5'd31, 32'h1234_5678); tick();
    drive_wr(1'b0, '0, '0);
    read_chk("dual31", 5'd31, 5'd31);
    chk("dual31_const", rdata2, 32'h1234_5678);

    // Back-to-back writes to one index: last edge wins.
    drive_wr(1'b1, 5'd12, 32'h1111_1111); tick();
    drive_wr(1'b1, 5'd12, 32'h2222_2222); tick();
    drive_wr(1'b0, '0, '0);
    read_chk("b2b", 5'd12, 5'd12);

    // Reset during a write: write lost, bypass disabled while low.
    drive_wr(1'b1, 5'd3, 32'd42);
    #2;
    assert_reset();
    #1;
    read_chk("rst_wr_low", 5'd3, 5'd3);
    tick();
    read_chk("rst_wr_edge", 5'd3, 5'd31);
    drive_wr(1'b0, '0, '0);
    rst_n = 1'b1;
    read_chk("rst_wr_after", 5'd3, 5'd3);
    chk("rst_wr_r3_const", rdata1, 32'd0);

    // First rising edge after release commits a write.
    drive_wr(1'b1, 5'd10, 32'hCAFE_0010); tick();
    drive_wr(1'b0, '0, '0);
    read_chk("first_wr", 5'd10, 5'd3);
    chk("first_wr_const", rdata1, 32'hCAFE_0010);

    // Random write/read mix against the model.
    for (int n = 0; n < 40; n++) begin
      drive_wr(1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 31)), word_t'($urandom));
      read_chk("rand", reg_idx_t'($urandom_range(0, 31)), waddr);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mips_reg_file
`default_nettype wire

// File: doc/mips_reg_file.md
# mips_reg_file

General-purpose register file for the MIPS datapath: 32 architectural registers, two combinational read ports, one clocked write port. Sits in the decode stage directly upstream of the ALU-source 2-to-1 multiplexer. Read port 2 feeds the multiplexer's register input (in1), opposite the sign-extended immediate (in2). Write-back results from the MEM/WB stage return through the write port.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; register count = 2**ADDR_W

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low
- we  input  1  write enable, sampled at rising clk
- waddr  input  ADDR_W  write register index
- wdata  input  DATA_W  write data
- raddr1  input  ADDR_W  read port 1 index (rs)
- raddr2  input  ADDR_W  read port 2 index (rt)
- rdata1  output  DATA_W  read port 1 data (rs value)
- rdata2  output  DATA_W  read port 2 data (rt value, to ALU-source mux in1)

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits. Register 0 is hardwired to zero.
- Write: at rising clk, when rst_n=1, we=1 and waddr!=0, entry[waddr] <= wdata. Writes with waddr=0 are discarded; entry 0 never changes.
- Read: rdata1 and rdata2 are combinational functions of raddrN, storage and the write port. No read enable.
- Write-through bypass: if we=1, waddr!=0, waddr==raddrN and rst_n=1, then rdataN = wdata in the same cycle, before the edge commits it. This lets WB and ID share a cycle without a hazard.
- raddrN=0 always returns 0, even when we=1 with waddr=0.
- raddr1==raddr2 is legal; both ports return the same value.
- Reset: rst_n=0 clears every entry to 0 immediately, without waiting for clk. While rst_n=0, rdata1 and rdata2 are 0, bypass is disabled and writes are ignored.
- Reset release: the first write can commit on the first rising clk with rst_n=1.

## Timing
- Read latency: 0 cycles, combinational from raddr, we, waddr and wdata.
- Write latency: 1 edge. Data written at edge N is visible from storage from edge N onward. Before edge N it is visible only through the bypass.
- Reset to outputs: asynchronous. rdataN are 0 within the same delta as rst_n falling.
- Reset mid-write: if rst_n falls in the cycle in which we=1, the write is lost and the entry reads 0.
- Back-to-back writes to the same index: the last edge wins. No write buffering.
- No handshake. The block never stalls and accepts one write per cycle.

## Structure
- The shared package mips_pkg holds:
  - DATA_W and ADDR_W defaults
  - the ZERO_REG=0 constant
  - the reg_idx_t and word_t typedefs, reused by the decoder and the pipeline registers
- No sub-module. Storage array, write logic and two identical read/bypass muxes live in a single module. Each read port is a repeated function or generate instance of the same bypass compare.

## Test plan
- Reset: rst_n=0 mid-simulation after registers 1..31 are loaded with nonzero values. Required: every raddr returns 0 immediately, and still returns 0 after rst_n=1 with we=0.
- Basic write/read: write 32'd5 to r8 and 32'd9 to r9 on consecutive edges, then raddr1=8, raddr2=9. Required: rdata1=5, rdata2=9.
- Zero register: we=1, waddr=0, wdata=32'hFFFF_FFFF; raddr1=0 before and after the edge. Required: rdata1=0 in both cycles.
- Bypass: r4 holds 7; set we=1, waddr=4, wdata=32'd0, raddr2=4 in the same cycle. Required: rdata2=0 before the edge and still 0 after it.
- Dual read same index: r31=32'h1234_5678, raddr1=raddr2=31. Required: both outputs read 32'h1234_5678.
- Reset during write: we=1, waddr=3, wdata=32'd42, with rst_n pulsed low before the edge. Required: r3 reads 0 after rst_n returns high.
